// File: rtl/pp_seq_gen.sv
// Serializes a captured WIDTH-bit pattern MSB first on w, repeated Repeat+1 times with GAP idle cycles between copies.
// Latency: first bit on w one edge after an accepted Start; Done pulses one cycle after the last bit.
// Backpressure: none; Start is only sampled in IDLE, Abort ends a transmission on the next edge.
//
// Ports:
//   Clk, Rst      - clock, synchronous active-high reset
//   Start, Abort  - transmit request (IDLE only) / immediate termination (SHIFT, GAP)
//   Pattern       - WIDTH-bit pattern captured on an accepted Start
//   Repeat        - extra transmissions captured on an accepted Start
//   w             - registered serial bit stream
//   Busy, Done    - high in SHIFT/GAP; one-cycle pulse on normal completion
module pp_seq_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [3:0]       Repeat,
    output logic             w,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam int                BIT_LAST_I = WIDTH - 1;
    localparam logic [CNT_W-1:0]  BIT_LAST   = BIT_LAST_I[CNT_W-1:0];

    // Only meaningful when GAP > 0; the GAP state is unreachable otherwise.
    localparam int          GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q,   pat_d;    // captured pattern, source for every repeat
    logic [WIDTH-1:0]   sh_q,    sh_d;     // bits still to be sent in the current copy
    logic [CNT_W-1:0]   bit_q,   bit_d;    // index of the bit currently on w
    logic [3:0]         rep_q,   rep_d;    // copies still owed after the current one
    logic [3:0]         gap_q,   gap_d;
    logic               w_q,     w_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        w_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Abort has priority over a simultaneous Start.
                if (Start && !Abort) begin
                    pat_d   = Pattern;
                    rep_d   = Repeat;
                    w_d     = Pattern[WIDTH-1];
                    sh_d    = {Pattern[WIDTH-2:0], 1'b0};
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (bit_q != BIT_LAST) begin
                    w_d   = sh_q[WIDTH-1];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    bit_d = bit_q + CNT_W'(1);
                end else if (rep_q != 4'd0) begin
                    rep_d = rep_q - 4'd1;
                    if (GAP == 0) begin
                        // Back-to-back: next MSB follows the LSB directly.
                        w_d     = pat_q[WIDTH-1];
                        sh_d    = {pat_q[WIDTH-2:0], 1'b0};
                        bit_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        gap_d   = 4'd0;
                        state_d = S_GAP;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end

            S_GAP: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    w_d     = pat_q[WIDTH-1];
                    sh_d    = {pat_q[WIDTH-2:0], 1'b0};
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end

            // Done is already showing; Abort and Start are ignored here.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            w_q     <= w_d;
        end
    end

    assign w    = w_q;
    assign Busy = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign Done = (state_q == S_DONE);

endmodule

// File: doc/pp_seq_gen.md
PP_SEQ_GEN -- requirements
Module: pp_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pattern length in bits (2..32).
REQ-002 SHALL have parameter GAP, default 2, idle cycles (w=0) inserted between repeated patterns (0..15).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request to transmit; sampled only in IDLE.
REQ-006 SHALL have port Abort  input  1  terminate transmission immediately.
REQ-007 SHALL have port Pattern  input  WIDTH  bit pattern to serialize, MSB first; captured on accepted Start.
REQ-008 SHALL have port Repeat  input  4  extra transmissions; total sends = Repeat+1; captured on accepted Start.
REQ-009 SHALL have port w  output  1  registered serial bit stream, for a sequence-detector input.
REQ-010 SHALL have port Busy  output  1  high while in SHIFT or GAP.
REQ-011 SHALL have port Done  output  1  one-cycle pulse on normal completion.

Function
REQ-012 SHALL implement states IDLE, SHIFT, GAP, DONE; encoding left to the implementation; unused encodings SHALL go to IDLE.
REQ-013 In IDLE with Start=1 and Abort=0 at edge k, SHALL capture Pattern into the shift register and Repeat into the repeat counter, enter SHIFT, and drive w=Pattern[WIDTH-1] after edge k.
REQ-014 In SHIFT, w after edge k+i SHALL equal captured bit WIDTH-1-i, for i=0..WIDTH-1; the bit counter SHALL count 0..WIDTH-1.
REQ-015 After the last bit, if the repeat counter is nonzero, the block SHALL decrement it and enter GAP with w=0 for exactly GAP cycles, then re-enter SHIFT from the captured pattern (MSB first).
REQ-016 If GAP=0, the next pattern's MSB SHALL follow the previous LSB on the next cycle with no idle bit.
REQ-017 After the last bit with repeat counter zero, the block SHALL enter DONE for one cycle with Done=1, w=0, Busy=0, then return to IDLE.
REQ-018 Total Busy cycles for one accepted Start SHALL be (Repeat+1)*WIDTH + Repeat*GAP.
REQ-019 Start in SHIFT, GAP or DONE SHALL be ignored, and the captured Pattern/Repeat SHALL not change.
REQ-020 Abort=1 in SHIFT or GAP SHALL, on the next edge, force IDLE, w=0, Busy=0, with no Done pulse.
REQ-021 Abort and Start both high in IDLE: Abort SHALL win; the block stays in IDLE.
REQ-022 Abort in DONE SHALL not suppress the Done pulse already in progress.
REQ-023 w SHALL be 0 in IDLE, GAP and DONE.
REQ-024 Pattern and Repeat changes during a transmission SHALL not affect the stream in progress.

Reset
REQ-025 Rst=1 at an edge SHALL force IDLE, w=0, Busy=0, Done=0, and clear the shift register, bit counter, repeat counter and gap counter.
REQ-026 Rst SHALL take priority over Start and Abort in every state, including mid-SHIFT; after Rst deasserts, the block SHALL wait for a new Start.

Verification
REQ-027 Start with Pattern=8'b10110010, Repeat=0 -> w=1,0,1,1,0,0,1,0 on 8 consecutive cycles; Busy high 8 cycles; Done=1 on the 9th; IDLE on the 10th.
REQ-028 Pattern=8'hA5, Repeat=1, GAP=2 -> w=10100101,0,0,10100101; Busy high 18 cycles; one Done pulse.
REQ-029 Abort after the 3rd bit of 8'hFF -> w=1,1,1, then 0 from the next cycle; Busy low; no Done; a later Start sends a full pattern.
REQ-030 Start pulsed with Pattern=8'h00 mid-transmission of 8'hF0 -> stream stays 11110000; the second Start is not queued.
REQ-031 Rst asserted at bit 5 of Repeat=3 -> w=0, Busy=0, Done=0 on the next cycle; no residual bits after Rst deasserts.
REQ-032 Start and Abort together in IDLE -> no transmission, w=0, Busy=0; GAP=0 with Repeat=2 on 8'h81 -> 24 back-to-back bits 10000001 x3.
